// File: rtl/mem_bit_counter_if.sv
// Control-slave and memory-master signal bundle for mem_bit_counter.
// The slave modport is the counter's view; the master modport is the CPU/memory side.
interface mem_bit_counter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic [1:0]        ctl_address;
  logic              ctl_chipselect;
  logic              ctl_write;
  logic [31:0]       ctl_writedata;
  logic [31:0]       ctl_readdata;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_clken;
  logic              mem_write;
  logic [3:0]        mem_byteenable;
  logic [DATA_W-1:0] mem_readdata;
  logic              irq;

  modport slave (
    input  ctl_address, ctl_chipselect, ctl_write, ctl_writedata,
    input  mem_readdata,
    output ctl_readdata, mem_address, mem_chipselect,
    output mem_clken, mem_write, mem_byteenable, irq
  );

  modport master (
    output ctl_address, ctl_chipselect, ctl_write, ctl_writedata,
    output mem_readdata,
    input  ctl_readdata, mem_address, mem_chipselect,
    input  mem_clken, mem_write, mem_byteenable, irq
  );
endinterface

// File: rtl/mem_bit_counter.sv
// Streams a window of memory words and accumulates their set-bit count.
// Define MEM_BIT_COUNTER_IRQ_EN to implement the CTRL IRQ_EN bit and irq output.
module mem_bit_counter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  mem_bit_counter_if.slave bus
);

  localparam int LEN_W = ADDR_W + 1;
  localparam int PC_W  = $clog2(DATA_W + 1);
  localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(1 << ADDR_W);
  localparam logic [31:0]       MAX_LEN32 = 32'(1 << ADDR_W);
  localparam logic [ADDR_W-1:0] A_ONE     = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  L_ONE     = LEN_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, addr_q;
  logic [LEN_W-1:0]  len_q, cnt_q;
  logic [31:0]       result_q;
  logic              done_q;
  logic              valid_q;
  logic              irq_en;
  logic              busy, issue, drain;

  logic wr_en, ctrl_wr, base_wr, len_wr, start;

  assign wr_en   = bus.ctl_chipselect & bus.ctl_write;
  assign ctrl_wr = wr_en && (bus.ctl_address == 2'd0);
  assign base_wr = wr_en && (bus.ctl_address == 2'd1) && !busy;
  assign len_wr  = wr_en && (bus.ctl_address == 2'd2) && !busy;
  assign start   = ctrl_wr && bus.ctl_writedata[0] && !busy;

  function automatic logic [PC_W-1:0] popcount(input logic [DATA_W-1:0] w);
    popcount = '0;
    for (int i = 0; i < DATA_W; i++)
      popcount = popcount + PC_W'(w[i]);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (len_q == '0) ? DRAIN : RUN;
      RUN:     if (cnt_q == L_ONE) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    issue = 1'b0;
    drain = 1'b0;
    unique case (state_q)
      IDLE:    ;
      RUN:     begin busy = 1'b1; issue = 1'b1; end
      DRAIN:   begin busy = 1'b1; drain = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q   <= '0;
      len_q    <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= issue;
      if (base_wr) base_q <= bus.ctl_writedata[ADDR_W-1:0];
      if (len_wr)
        len_q <= (bus.ctl_writedata > MAX_LEN32)
               ? MAX_LEN : bus.ctl_writedata[LEN_W-1:0];
      if (start) begin
        addr_q   <= base_q;
        cnt_q    <= len_q;
        result_q <= '0;
      end else begin
        if (issue) begin
          addr_q <= addr_q + A_ONE;
          cnt_q  <= cnt_q - L_ONE;
        end
        if (valid_q)
          result_q <= result_q + 32'(popcount(bus.mem_readdata));
      end
      // completion outranks a same-cycle software clear
      if (drain)
        done_q <= 1'b1;
      else if (start || (ctrl_wr && bus.ctl_writedata[1]))
        done_q <= 1'b0;
    end
  end

`ifdef MEM_BIT_COUNTER_IRQ_EN
  logic irq_en_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        irq_en_q <= 1'b0;
    else if (ctrl_wr) irq_en_q <= bus.ctl_writedata[2];
  end
  assign irq_en  = irq_en_q;
  assign bus.irq = done_q & irq_en_q;
`else
  assign irq_en  = 1'b0;
  assign bus.irq = 1'b0;
`endif

  always_comb begin
    bus.ctl_readdata = '0;
    unique case (bus.ctl_address)
      2'd0: bus.ctl_readdata[2:0]        = {irq_en, done_q, busy};
      2'd1: bus.ctl_readdata[ADDR_W-1:0] = base_q;
      2'd2: bus.ctl_readdata[LEN_W-1:0]  = len_q;
      2'd3: bus.ctl_readdata             = result_q;
      default: ;
    endcase
  end

  assign bus.mem_address    = addr_q;
  assign bus.mem_chipselect = issue;
  assign bus.mem_clken      = 1'b1;
  assign bus.mem_write      = 1'b0;
  assign bus.mem_byteenable = 4'hF;

endmodule

// File: tb/tb_mem_bit_counter.sv
// Directed bench for mem_bit_counter with a one-cycle-latency memory model.
// Cycle numbering: cycle 0 is the cycle in which the start write is presented.
module tb_mem_bit_counter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_bit_counter_if #(.ADDR_W(11), .DATA_W(32)) bus ();

  mem_bit_counter #(.ADDR_W(11), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:2047];
  int tests = 0;
  int fails = 0;

`ifdef MEM_BIT_COUNTER_IRQ_EN
  localparam logic [31:0] EN = 32'd4;
`else
  localparam logic [31:0] EN = 32'd0;
`endif
  localparam logic [31:0] GO  = 32'd1 | EN;
  localparam logic [31:0] CLR = 32'd2 | EN;

  always @(posedge clk) bus.mem_readdata <= mem[bus.mem_address];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.ctl_chipselect = 1'b1;
    bus.ctl_write      = 1'b1;
    bus.ctl_address    = a;
    bus.ctl_writedata  = d;
    step();
    bus.ctl_chipselect = 1'b0;
    bus.ctl_write      = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.ctl_address = a;
    #1;
    d = bus.ctl_readdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
    wr(2'd1, 32'h5);
    wr(2'd2, 32'h3);
    reset = 1'b1;
    #1;
    for (int r = 0; r < 4; r++) begin
      rd(2'(r), d);
      tests++;
      if (d !== 32'h0) begin
        fails++;
        $display("FAIL reset_reg%0d got %h want 0", r, d);
      end
    end
    tests++;
    if (bus.mem_chipselect !== 1'b0 || bus.irq !== 1'b0 ||
        bus.mem_address !== 11'h0) begin
      fails++;
      $display("FAIL reset_outs cs=%b irq=%b addr=%h want 0/0/0",
               bus.mem_chipselect, bus.irq, bus.mem_address);
    end
    tests++;
    if (bus.mem_clken !== 1'b1 || bus.mem_write !== 1'b0 ||
        bus.mem_byteenable !== 4'hF) begin
      fails++;
      $display("FAIL reset_const clken=%b wr=%b be=%h want 1/0/F",
               bus.mem_clken, bus.mem_write, bus.mem_byteenable);
    end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [31:0] d;
    mem[0] = 32'hFFFF_FFFF;
    mem[1] = 32'h0000_0000;
    mem[2] = 32'h0000_0001;
    mem[3] = 32'h8000_0001;
    wr(2'd1, 32'h0);
    wr(2'd2, 32'h4);
    wr(2'd0, GO);
    for (int c = 1; c <= 4; c++) begin
      tests++;
      if (bus.mem_chipselect !== 1'b1 || bus.mem_address !== 11'(c - 1)) begin
        fails++;
        $display("FAIL basic_addr c%0d got cs=%b a=%h want 1/%h",
                 c, bus.mem_chipselect, bus.mem_address, c - 1);
      end
      step();
    end
    rd(2'd0, d);
    tests++;
    if (d[1:0] !== 2'b01 || bus.mem_chipselect !== 1'b0) begin
      fails++;
      $display("FAIL basic_drain got st=%b cs=%b want 01/0",
               d[1:0], bus.mem_chipselect);
    end
    step();
    rd(2'd0, d);
    tests++;
    if (d[1:0] !== 2'b10) begin
      fails++;
      $display("FAIL basic_done got %b want 10", d[1:0]);
    end
    rd(2'd3, d);
    tests++;
    if (d !== 32'd35) begin
      fails++;
      $display("FAIL basic_result got %0d want 35", d);
    end
  endtask

  task automatic test_zero_len();
    logic [31:0] d;
    wr(2'd2, 32'h0);
    wr(2'd0, GO);
    rd(2'd0, d);
    tests++;
    if (d[1:0] !== 2'b01 || bus.mem_chipselect !== 1'b0) begin
      fails++;
      $display("FAIL zero_c1 got st=%b cs=%b want 01/0",
               d[1:0], bus.mem_chipselect);
    end
    step();
    rd(2'd0, d);
    tests++;
    if (d[1:0] !== 2'b10 || bus.mem_chipselect !== 1'b0) begin
      fails++;
      $display("FAIL zero_c2 got st=%b cs=%b want 10/0",
               d[1:0], bus.mem_chipselect);
    end
    rd(2'd3, d);
    tests++;
    if (d !== 32'd0) begin
      fails++;
      $display("FAIL zero_result got %0d want 0", d);
    end
  endtask

  task automatic test_clear_race();
    logic [31:0] d;
    wr(2'd2, 32'h0);
    wr(2'd0, GO);
    wr(2'd0, CLR);
    rd(2'd0, d);
    tests++;
    if (d[1] !== 1'b1) begin
      fails++;
      $display("FAIL race_done got %b want 1", d[1]);
    end
    wr(2'd0, CLR);
    rd(2'd0, d);
    tests++;
    if (d[1:0] !== 2'b00) begin
      fails++;
      $display("FAIL clear_done got %b want 00", d[1:0]);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    logic [10:0] exp_a [4];
    exp_a[0] = 11'h7FE;
    exp_a[1] = 11'h7FF;
    exp_a[2] = 11'h000;
    exp_a[3] = 11'h001;
    for (int i = 0; i < 4; i++) mem[exp_a[i]] = 32'h0000_000F;
    wr(2'd1, 32'h7FE);
    wr(2'd2, 32'h4);
    wr(2'd0, GO);
    for (int c = 0; c < 4; c++) begin
      tests++;
      if (bus.mem_chipselect !== 1'b1 || bus.mem_address !== exp_a[c]) begin
        fails++;
        $display("FAIL wrap_addr c%0d got cs=%b a=%h want 1/%h",
                 c + 1, bus.mem_chipselect, bus.mem_address, exp_a[c]);
      end
      step();
    end
    step();
    rd(2'd3, d);
    tests++;
    if (d !== 32'd16) begin
      fails++;
      $display("FAIL wrap_result got %0d want 16", d);
    end
  endtask

  task automatic test_saturate();
    logic [31:0] d;
    int cyc;
    for (int i = 0; i < 2048; i++) mem[i] = 32'hFFFF_FFFF;
    wr(2'd1, 32'h10);
    wr(2'd2, 32'd5000);
    rd(2'd2, d);
    tests++;
    if (d !== 32'd2048) begin
      fails++;
      $display("FAIL sat_len got %0d want 2048", d);
    end
    wr(2'd0, GO);
    wr(2'd1, 32'h55);
    wr(2'd0, GO);
    cyc = 3;
    tests++;
    if (bus.mem_address !== 11'h12) begin
      fails++;
      $display("FAIL sat_restart got a=%h want 012", bus.mem_address);
    end
    rd(2'd1, d);
    tests++;
    if (d !== 32'h10) begin
      fails++;
      $display("FAIL sat_base got %h want 10", d);
    end
    rd(2'd0, d);
    while (d[0] === 1'b1 && cyc < 2100) begin
      step();
      cyc++;
      rd(2'd0, d);
    end
    tests++;
    if (cyc != 2050 || d[1:0] !== 2'b10) begin
      fails++;
      $display("FAIL sat_latency got cycle %0d st=%b want 2050/10",
               cyc, d[1:0]);
    end
    rd(2'd3, d);
    tests++;
    if (d !== 32'd65536) begin
      fails++;
      $display("FAIL sat_result got %0d want 65536", d);
    end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    wr(2'd0, 32'h4);
    rd(2'd0, d);
    tests++;
    if (d[2] !== EN[2]) begin
      fails++;
      $display("FAIL irq_en_bit got %b want %b", d[2], EN[2]);
    end
    wr(2'd2, 32'h1);
    wr(2'd0, GO);
    step();
    tests++;
    if (bus.irq !== 1'b0) begin
      fails++;
      $display("FAIL irq_early got %b want 0", bus.irq);
    end
    step();
    rd(2'd0, d);
    tests++;
    if (bus.irq !== EN[2] || d[1] !== 1'b1) begin
      fails++;
      $display("FAIL irq_rise got irq=%b done=%b want %b/1",
               bus.irq, d[1], EN[2]);
    end
    wr(2'd0, CLR);
    tests++;
    if (bus.irq !== 1'b0) begin
      fails++;
      $display("FAIL irq_clear got %b want 0", bus.irq);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] d;
    wr(2'd1, 32'h0);
    wr(2'd2, 32'h8);
    wr(2'd0, GO);
    step();
    reset = 1'b1;
    #1;
    tests++;
    if (bus.mem_chipselect !== 1'b0 || bus.irq !== 1'b0 ||
        bus.mem_address !== 11'h0) begin
      fails++;
      $display("FAIL midrst_outs cs=%b irq=%b a=%h want 0/0/0",
               bus.mem_chipselect, bus.irq, bus.mem_address);
    end
    rd(2'd0, d);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL midrst_ctrl got %h want 0", d);
    end
    rd(2'd3, d);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL midrst_result got %h want 0", d);
    end
    step();
    reset = 1'b0;
    repeat (2) step();
    rd(2'd0, d);
    tests++;
    if (d !== 32'h0 || bus.mem_chipselect !== 1'b0) begin
      fails++;
      $display("FAIL midrst_idle got ctrl=%h cs=%b want 0/0",
               d, bus.mem_chipselect);
    end
  endtask

  initial begin
    reset              = 1'b1;
    bus.ctl_address    = 2'd0;
    bus.ctl_chipselect = 1'b0;
    bus.ctl_write      = 1'b0;
    bus.ctl_writedata  = 32'h0;
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    test_reset();
    test_basic();
    test_zero_len();
    test_clear_race();
    test_wrap();
    test_saturate();
    test_irq();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
